// File: rtl/median3x3_pipe_if.sv
// Column-in / median-out bundle for median3x3_pipe.
// SORTER_MINMAX_EN adds the window min/max outputs.
interface median3x3_pipe_if #(parameter int DATA_W = 8);
    logic              iValid;
    logic              iClear;
    logic [DATA_W-1:0] iPixTop;
    logic [DATA_W-1:0] iPixMid;
    logic [DATA_W-1:0] iPixBot;
    logic              oValid;
    logic [DATA_W-1:0] oMedian;
`ifdef SORTER_MINMAX_EN
    logic [DATA_W-1:0] oMin;
    logic [DATA_W-1:0] oMax;
`endif

    modport master (
        output iValid, iClear, iPixTop, iPixMid, iPixBot,
        input  oValid, oMedian
`ifdef SORTER_MINMAX_EN
        , input oMin, oMax
`endif
    );

    modport slave (
        input  iValid, iClear, iPixTop, iPixMid, iPixBot,
        output oValid, oMedian
`ifdef SORTER_MINMAX_EN
        , output oMin, oMax
`endif
    );
endinterface

// File: rtl/median3x3_pipe.sv
// 4-stage 3x3 median: column sort, 3-column window, per-lane reduce, final median.
// Define SORTER_MINMAX_EN to also produce window min/max on the bus.
module median3x3_sort3 #(parameter int W = 8) (
    input  logic [2:0][W-1:0] din,
    output logic [2:0][W-1:0] dout
);
    logic [W-1:0] x0, x1, y1;

    // Three compare-swaps; equal values pass straight through.
    assign x0      = (din[1] < din[0]) ? din[1] : din[0];
    assign x1      = (din[1] < din[0]) ? din[0] : din[1];
    assign y1      = (din[2] < x1)     ? din[2] : x1;
    assign dout[2] = (din[2] < x1)     ? x1     : din[2];
    assign dout[0] = (y1 < x0)         ? y1     : x0;
    assign dout[1] = (y1 < x0)         ? x0     : y1;
endmodule

module median3x3_pipe #(parameter int DATA_W = 8) (
    input logic              iClk,
    input logic              iRst_n,
    median3x3_pipe_if.slave  bus
);
    typedef logic [2:0][DATA_W-1:0] colT;

    logic [3:1]        vldPipe;
    logic              c1;
    colT               s1In, s1Sort, s1Col;
    colT [2:0]         hist;
    logic [1:0]        fillCnt, fillNext;
    colT [2:0]         laneOut;
    logic [DATA_W-1:0] maxLo, medMid, minHi;
    colT               finSort;
    logic              oValidR;
    logic [DATA_W-1:0] oMedianR;
    logic              unusedBits;

    // S1: sort the incoming column
    assign s1In = {bus.iPixBot, bus.iPixMid, bus.iPixTop};
    median3x3_sort3 #(.W(DATA_W)) uColSort (.din(s1In), .dout(s1Sort));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            vldPipe[1] <= 1'b0;
            c1         <= 1'b0;
            s1Col      <= '0;
        end else begin
            vldPipe[1] <= bus.iValid;
            c1         <= bus.iValid & bus.iClear;
            if (bus.iValid) s1Col <= s1Sort;
        end
    end

    // S2: history shift; a clear makes this column the first of a new window
    assign fillNext = c1 ? 2'd1 : ((fillCnt == 2'd3) ? 2'd3 : fillCnt + 2'd1);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            vldPipe[2] <= 1'b0;
            hist       <= '0;
            fillCnt    <= '0;
        end else begin
            vldPipe[2] <= vldPipe[1] && (fillNext == 2'd3);
            if (vldPipe[1]) begin
                hist    <= {hist[1:0], s1Col};
                fillCnt <= fillNext;
            end
        end
    end

    // S3: lane k sorts the k-th ranked value of each column
    genvar k;
    generate
        for (k = 0; k < 3; k++) begin : gLane
            colT laneIn;
            assign laneIn = {hist[2][k], hist[1][k], hist[0][k]};
            median3x3_sort3 #(.W(DATA_W)) uLane (.din(laneIn), .dout(laneOut[k]));
        end
    endgenerate

`ifdef SORTER_MINMAX_EN
    logic [DATA_W-1:0] minLo, maxHi, oMinR, oMaxR;
`endif

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            vldPipe[3] <= 1'b0;
            maxLo      <= '0;
            medMid     <= '0;
            minHi      <= '0;
`ifdef SORTER_MINMAX_EN
            minLo      <= '0;
            maxHi      <= '0;
`endif
        end else begin
            vldPipe[3] <= vldPipe[2];
            if (vldPipe[2]) begin
                maxLo  <= laneOut[0][2];
                medMid <= laneOut[1][1];
                minHi  <= laneOut[2][0];
`ifdef SORTER_MINMAX_EN
                minLo  <= laneOut[0][0];
                maxHi  <= laneOut[2][2];
`endif
            end
        end
    end

    // S4: median of the three lane survivors is the window median
    median3x3_sort3 #(.W(DATA_W)) uFinal (.din({minHi, medMid, maxLo}), .dout(finSort));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oValidR  <= 1'b0;
            oMedianR <= '0;
`ifdef SORTER_MINMAX_EN
            oMinR    <= '0;
            oMaxR    <= '0;
`endif
        end else begin
            oValidR <= vldPipe[3];
            if (vldPipe[3]) begin
                oMedianR <= finSort[1];
`ifdef SORTER_MINMAX_EN
                oMinR    <= minLo;
                oMaxR    <= maxHi;
`endif
            end
        end
    end

    assign bus.oValid  = oValidR;
    assign bus.oMedian = oMedianR;
`ifdef SORTER_MINMAX_EN
    assign bus.oMin    = oMinR;
    assign bus.oMax    = oMaxR;
    assign unusedBits  = ^{laneOut[0][1], laneOut[1][2], laneOut[1][0], laneOut[2][1],
                           finSort[2], finSort[0]};
`else
    assign unusedBits  = ^{laneOut[0][1:0], laneOut[1][2], laneOut[1][0], laneOut[2][2:1],
                           finSort[2], finSort[0]};
`endif
endmodule

// File: tb/tb_median3x3_pipe.sv
// Bench for median3x3_pipe: directed plan steps plus random columns against a sort-of-nine model.
module tb_median3x3_pipe;
    localparam int W = 12;

    logic iClk = 1'b0;
    logic iRst_n = 1'b1;

    median3x3_pipe_if #(.DATA_W(W)) bus ();
    median3x3_pipe #(.DATA_W(W)) dut (.iClk(iClk), .iRst_n(iRst_n), .bus(bus));

    always #5 iClk = ~iClk;

    typedef struct { int sEdge; int med; int mn; int mx; } expT;
    expT expQ[$];
    int  win[$];
    int  dutMeds[$];
    int  dutMins[$];
    int  dutMaxs[$];
    int  checks = 0, errors = 0, cyc = 0;
    int  lastMed = 0, lastMin = 0, lastMax = 0;

    always @(posedge iClk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: window = last three valid columns since the last clear.
    task automatic drive(input int t, input int m, input int b, input bit clr);
        int q[$];
        @(posedge iClk); #1;
        bus.iValid = 1'b1; bus.iClear = clr;
        bus.iPixTop = t[W-1:0]; bus.iPixMid = m[W-1:0]; bus.iPixBot = b[W-1:0];
        if (clr) win.delete();
        win.push_back(t); win.push_back(m); win.push_back(b);
        while (win.size() > 9) void'(win.pop_front());
        if (win.size() == 9) begin
            q = win;
            q.sort();
            expQ.push_back('{cyc + 4, q[4], q[0], q[8]});
        end
    endtask

    task automatic idle(input int n, input bit clr);
        for (int i = 0; i < n; i++) begin
            @(posedge iClk); #1;
            bus.iValid = 1'b0; bus.iClear = clr;
            bus.iPixTop = W'($urandom); bus.iPixMid = W'($urandom); bus.iPixBot = W'($urandom);
        end
    endtask

    task automatic doReset();
        @(posedge iClk); #3;
        bus.iValid = 1'b0; bus.iClear = 1'b0;
        iRst_n = 1'b0;
        expQ.delete(); win.delete();
        lastMed = 0; lastMin = 0; lastMax = 0;
        #1;
        chk("async_rst_valid", bus.oValid, 0);
        chk("async_rst_median", bus.oMedian, 0);
`ifdef SORTER_MINMAX_EN
        chk("async_rst_min", bus.oMin, 0);
        chk("async_rst_max", bus.oMax, 0);
`endif
        repeat (3) @(posedge iClk);
        #1 iRst_n = 1'b1;
    endtask

    always @(negedge iClk) begin
        bit expV;
        expV = (expQ.size() > 0) && (expQ[0].sEdge == cyc);
        if (expV) begin
            lastMed = expQ[0].med; lastMin = expQ[0].mn; lastMax = expQ[0].mx;
            void'(expQ.pop_front());
        end
        chk("ovalid", bus.oValid, expV);
        chk("omedian", bus.oMedian, lastMed[W-1:0]);
`ifdef SORTER_MINMAX_EN
        chk("omin", bus.oMin, lastMin[W-1:0]);
        chk("omax", bus.oMax, lastMax[W-1:0]);
`endif
        if (bus.oValid === 1'b1) begin
            dutMeds.push_back(int'(bus.oMedian));
`ifdef SORTER_MINMAX_EN
            dutMins.push_back(int'(bus.oMin));
            dutMaxs.push_back(int'(bus.oMax));
`endif
        end
    end

    initial begin
        bus.iValid = 1'b0; bus.iClear = 1'b0;
        bus.iPixTop = '0; bus.iPixMid = '0; bus.iPixBot = '0;
        #1 iRst_n = 1'b0;
        repeat (3) @(posedge iClk);
        #1 iRst_n = 1'b1;
        idle(10, 1'b0);
        chk("reset_no_strobe", dutMeds.size(), 0);

        // basic window followed by a streaming fourth column
        dutMeds.delete(); dutMins.delete(); dutMaxs.delete();
        drive(9, 1, 5, 1'b1); drive(3, 7, 2, 1'b0); drive(8, 4, 6, 1'b0); drive(0, 0, 0, 1'b0);
        idle(6, 1'b0);
        chk("stream_count", dutMeds.size(), 2);
        if (dutMeds.size() == 2) begin
            chk("basic_median", dutMeds[0], 5);
            chk("stream_median", dutMeds[1], 3);
`ifdef SORTER_MINMAX_EN
            chk("basic_min", dutMins[0], 1);
            chk("basic_max", dutMaxs[0], 9);
            chk("stream_min", dutMins[1], 0);
            chk("stream_max", dutMaxs[1], 8);
`endif
        end

        // bubbles between columns, with an ignored clear while idle
        dutMeds.delete();
        drive(9, 1, 5, 1'b1); idle(2, 1'b1);
        drive(3, 7, 2, 1'b0); idle(2, 1'b0);
        drive(8, 4, 6, 1'b0); idle(8, 1'b0);
        chk("bubble_count", dutMeds.size(), 1);
        if (dutMeds.size() == 1) chk("bubble_median", dutMeds[0], 5);

        // clear mid-line
        dutMeds.delete();
        drive(9, 1, 5, 1'b1); drive(3, 7, 2, 1'b0); drive(8, 4, 6, 1'b1);
        drive(2, 2, 2, 1'b0); drive(6, 6, 6, 1'b0);
        idle(6, 1'b0);
        chk("clear_count", dutMeds.size(), 1);
        if (dutMeds.size() == 1) chk("clear_median", dutMeds[0], 6);

        // full-width values, then async reset mid-stream
        dutMeds.delete(); dutMins.delete();
        drive(4095, 4095, 4095, 1'b1); drive(4095, 0, 4095, 1'b0); drive(4095, 4095, 4095, 1'b0);
        idle(6, 1'b0);
        chk("width_count", dutMeds.size(), 1);
        if (dutMeds.size() == 1) chk("width_median", dutMeds[0], 4095);
`ifdef SORTER_MINMAX_EN
        if (dutMins.size() == 1) chk("width_min", dutMins[0], 0);
`endif
        drive(100, 200, 300, 1'b0); drive(7, 8, 9, 1'b0);
        doReset();
        dutMeds.delete();
        drive(1, 2, 3, 1'b0); drive(4, 5, 6, 1'b0); idle(6, 1'b0);
        chk("post_reset_two_cols", dutMeds.size(), 0);
        drive(7, 8, 9, 1'b0); idle(6, 1'b0);
        chk("post_reset_third_col", dutMeds.size(), 1);
        if (dutMeds.size() == 1) chk("post_reset_median", dutMeds[0], 5);

        // random columns, bubbles and clears
        for (int i = 0; i < 400; i++) begin
            int t, m, b;
            t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 4095));
            m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 4095));
            b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 4095));
            if ($urandom_range(0, 6) == 0) idle(int'($urandom_range(1, 3)), 1'($urandom));
            drive(t, m, b, $urandom_range(0, 19) == 0);
        end
        idle(8, 1'b0);
        chk("drained", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/median3x3_pipe.md
# median3x3_pipe

Pipelined, parametrised 3×3 median kernel for the median-filter datapath. It accepts one vertical column of three pixels per valid cycle and keeps the last three sorted columns as a sliding window. For every full window it emits the median of its nine pixels. It sits downstream of the line buffers, which supply the column, and upstream of the pixel output stage.

## Interface
- `DATA_W`, default 8: pixel width in bits.
- `iClk`  in  1: clock; all logic is on the rising edge.
- `iRst_n`  in  1: reset, asynchronous, active-low.
- `iValid`  in  1: the column on `iPixTop/iPixMid/iPixBot` is valid this cycle.
- `iClear`  in  1: start of a new line; sampled only while `iValid` is high.
- `iPixTop`  in  `DATA_W`: top pixel of the column.
- `iPixMid`  in  `DATA_W`: middle pixel of the column.
- `iPixBot`  in  `DATA_W`: bottom pixel of the column.
- `oValid`  out  1: single-cycle strobe; `oMedian` is new this cycle.
- `oMedian`  out  `DATA_W`: median of the 9-pixel window.
- `oMin`  out  `DATA_W`: window minimum (only with `SORTER_MINMAX_EN`).
- `oMax`  out  `DATA_W`: window maximum (only with `SORTER_MINMAX_EN`).

## Operation
- **S1 (column sort):** on a cycle with `iValid` high, the incoming column is sorted with a 3-comparator network into lo/mid/hi and registered. `v1` and `c1` register `iValid` and `iValid & iClear`.
- **S2 (window):** when `v1` is high, the sorted column shifts into a 3-deep history (col0 newest, col2 oldest). A fill counter runs 0..3 and saturates at 3.
  - If `c1` is set, the counter reloads to 1: the current column is the first column of the new window.
  - Otherwise the counter increments, saturating at 3.
  - When `v1` is low (a bubble), the history and counter hold.
  - `v2 = v1 & (next count == 3)`.
- **S3 (reduce):** registers maxLo = max of the three lo values, medMid = median of the three mid values, and minHi = min of the three hi values. `v3 = v2`.
- **S4 (output):** `oMedian` = median(maxLo, medMid, minHi). `oValid = v3`.
- `oMedian` is loaded only when `v3` is high; otherwise it holds its last value.
- Ties are legal: comparators pass through equal values, and the result depends only on values.
- All arithmetic is unsigned at `DATA_W` bits, with no width growth.
- Clearing does not flush S3/S4. A window already formed still emits after `iClear`.
- Reset mid-operation clears everything. A new window then needs 3 fresh valid columns.

## Timing
- **Reset values:** every register is 0. That gives `oValid`=0, `oMedian`=0, `oMin`=0, `oMax`=0, and fill count 0.
- **Latency:** take the edge that samples the third column of a window as edge 1. `oValid` and `oMedian` are updated by edge 4, so they are visible for one cycle after edge 4.
- **Throughput:** one window per clock once the window is full and columns are back-to-back.
- **No back-pressure:** the block is always ready.
- **Bubbles:** each idle cycle between columns delays the output by one cycle. Results are unaffected.
- **`iClear` with `iValid` low:** ignored.

## Configuration
- `SORTER_MINMAX_EN` defined:
  - Adds ports `oMin` and `oMax`.
  - S3 additionally registers the min of the lo values and the max of the hi values.
  - S4 registers them alongside `oMedian`, with identical latency, strobe and hold rules.
- `SORTER_MINMAX_EN` undefined:
  - The ports and logic are absent.
  - Median behaviour is identical in both builds.

## Test plan
- **Reset:** hold `iRst_n` low for 3 cycles, then release with `iValid`=0 for 10 cycles. All outputs stay 0 and `oValid` never rises.
- **Basic window:** drive columns (9,1,5) with `iClear`=1, then (3,7,2) and (8,4,6) back-to-back. `oValid` pulses exactly once, on edge 4 counting the third column's edge as 1. Values: `oMedian`=5, `oMin`=1, `oMax`=9. There is no strobe for the first two columns.
- **Streaming:** follow the basic window immediately with (0,0,0). `oValid` is high for 2 consecutive cycles: `oMedian`=5 and then 3. The second window has `oMin`=0 and `oMax`=8.
- **Bubbles:** drive the same three columns with 2 idle cycles between each. The result is a single strobe with `oMedian`=5. `oMedian` holds between strobes.
- **Clear mid-line:** drive (9,1,5) and (3,7,2), then (8,4,6) with `iClear`=1, then (2,2,2) and (6,6,6). Exactly one strobe follows, after (6,6,6), with `oMedian`=6. The sorted window is 2,2,2,4,6,6,6,6,8.
- **Width and async reset:** with `DATA_W`=12, fill a window with all 4095 except one 0. `oMedian`=4095, `oMin`=0. Assert `iRst_n` low mid-stream: outputs go to 0 immediately, without waiting for a clock edge. After release, no strobe appears until 3 new columns are driven.
